// File: rtl/hdlc_rx_deframer_if.sv
// Serial input and frame/byte output bundle for the HDLC receive deframer.
// Rx_Idle exists only when HDLC_RX_IDLE_DETECT_EN is defined.
interface hdlc_rx_deframer_if #(
    parameter int LEN_W = 8
);
    logic             Rx;
    logic             RxEN;
    logic [7:0]       DataOut;
    logic             Rx_DataValid;
    logic             Rx_FlagDetect;
    logic             Rx_AbortDetect;
    logic             Rx_ValidFrame;
    logic             Rx_EoF;
    logic             Rx_FrameError;
    logic [LEN_W-1:0] Rx_FrameLen;
`ifdef HDLC_RX_IDLE_DETECT_EN
    logic             Rx_Idle;

    modport master (
        output Rx, RxEN,
        input  DataOut, Rx_DataValid, Rx_FlagDetect, Rx_AbortDetect,
        input  Rx_ValidFrame, Rx_EoF, Rx_FrameError, Rx_FrameLen,
        input  Rx_Idle
    );
    modport slave (
        input  Rx, RxEN,
        output DataOut, Rx_DataValid, Rx_FlagDetect, Rx_AbortDetect,
        output Rx_ValidFrame, Rx_EoF, Rx_FrameError, Rx_FrameLen,
        output Rx_Idle
    );
`else
    modport master (
        output Rx, RxEN,
        input  DataOut, Rx_DataValid, Rx_FlagDetect, Rx_AbortDetect,
        input  Rx_ValidFrame, Rx_EoF, Rx_FrameError, Rx_FrameLen
    );
    modport slave (
        input  Rx, RxEN,
        output DataOut, Rx_DataValid, Rx_FlagDetect, Rx_AbortDetect,
        output Rx_ValidFrame, Rx_EoF, Rx_FrameError, Rx_FrameLen
    );
`endif
endinterface

// File: rtl/hdlc_rx_deframer.sv
// HDLC bit-level receiver: flag hunt, destuffing, abort, octets, FCS, length.
// Optional idle-line output under macro HDLC_RX_IDLE_DETECT_EN.
module hdlc_rx_deframer #(
    parameter int FCS_WIDTH       = 16,
    parameter int MIN_FRAME_BYTES = 4,
    parameter int MAX_FRAME_BYTES = 130,
    parameter int LEN_W           = 8
) (
    input logic               Clk,
    input logic               Rst,
    hdlc_rx_deframer_if.slave bus
);
    localparam int FCS_BYTES = FCS_WIDTH / 8;
    localparam logic [FCS_WIDTH-1:0] CRC_POLY =
        FCS_WIDTH'((FCS_WIDTH == 32) ? 32'hEDB88320 : 32'h00008408);
    localparam logic [FCS_WIDTH-1:0] CRC_GOOD =
        FCS_WIDTH'((FCS_WIDTH == 32) ? 32'hDEBB20E3 : 32'h0000F0B8);
    localparam logic [LEN_W-1:0] MIN_L   = LEN_W'(MIN_FRAME_BYTES);
    localparam logic [LEN_W-1:0] MAX_L   = LEN_W'(MAX_FRAME_BYTES);
    localparam logic [LEN_W-1:0] FCS_L   = LEN_W'(FCS_BYTES);
    localparam logic [LEN_W-1:0] CNT_SAT = '1;

    typedef enum logic [1:0] {HUNT, FLAG, DATA} state_t;

    function automatic logic [FCS_WIDTH-1:0] crc_byte(
        input logic [FCS_WIDTH-1:0] c,
        input logic [7:0]           b
    );
        logic [FCS_WIDTH-1:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[0] ^ b[i]) r = (r >> 1) ^ CRC_POLY;
            else             r = r >> 1;
        end
        return r;
    endfunction

    state_t               state_q, state_d;
    logic [3:0]           ones_q, ones_d;
    logic [6:0]           dl_q, dl_d;
    logic [2:0]           dl_cnt_q, dl_cnt_d;
    logic [7:0]           asm_q, asm_d;
    logic [2:0]           bit_cnt_q, bit_cnt_d;
    logic [FCS_WIDTH-1:0] hold_q, hold_d;
    logic [FCS_WIDTH-1:0] crc_q, crc_d;
    logic [LEN_W-1:0]     byte_cnt_q, byte_cnt_d;
    logic [7:0]           data_q, data_d;
    logic                 dv_q, dv_d;
    logic                 flag_q, flag_d;
    logic                 abort_q, abort_d;
    logic                 vf_q, vf_d;
    logic                 eof_q, eof_d;
    logic                 err_q, err_d;
    logic [LEN_W-1:0]     len_q, len_d;

    logic                 is_flag, is_abort, is_stuff;
    logic                 bit_v, bit_out;
    logic [7:0]           byte_v;
    logic [LEN_W-1:0]     eff_len;

    always_comb begin
        state_d    = state_q;
        ones_d     = ones_q;
        dl_d       = dl_q;
        dl_cnt_d   = dl_cnt_q;
        asm_d      = asm_q;
        bit_cnt_d  = bit_cnt_q;
        hold_d     = hold_q;
        crc_d      = crc_q;
        byte_cnt_d = byte_cnt_q;
        data_d     = data_q;
        vf_d       = vf_q;
        dv_d       = 1'b0;
        flag_d     = 1'b0;
        abort_d    = 1'b0;
        eof_d      = 1'b0;
        err_d      = 1'b0;
        len_d      = '0;
        is_flag    = 1'b0;
        is_abort   = 1'b0;
        is_stuff   = 1'b0;
        bit_v      = 1'b0;
        bit_out    = 1'b0;
        byte_v     = '0;
        eff_len    = '0;
        if (bus.RxEN) begin
            if (bus.Rx) ones_d = (ones_q == 4'hF) ? ones_q : ones_q + 4'd1;
            else        ones_d = '0;
            is_flag  = !bus.Rx && (ones_q == 4'd6);
            is_abort =  bus.Rx && (ones_q == 4'd6);
            is_stuff = !bus.Rx && (ones_q == 4'd5);
            // Seven-deep delay hides the 0+six-1s prefix of any flag/abort
            if (is_flag || is_abort) begin
                dl_cnt_d = '0;
            end else if (!is_stuff) begin
                bit_v   = (dl_cnt_q == 3'd7);
                bit_out = dl_q[6];
                dl_d    = {dl_q[5:0], bus.Rx};
                if (!bit_v) dl_cnt_d = dl_cnt_q + 3'd1;
            end
            if (is_abort) begin
                abort_d = 1'b1;
                vf_d    = 1'b0;
                state_d = HUNT;
            end else if (is_flag) begin
                flag_d     = 1'b1;
                state_d    = FLAG;
                bit_cnt_d  = '0;
                byte_cnt_d = '0;
                if (state_q == DATA) begin
                    eof_d   = 1'b1;
                    vf_d    = 1'b0;
                    err_d   = (bit_cnt_q != 3'd0) || (byte_cnt_q < MIN_L) ||
                              (byte_cnt_q > MAX_L) || (crc_q != CRC_GOOD);
                    eff_len = (byte_cnt_q > MAX_L) ? MAX_L : byte_cnt_q;
                    len_d   = (eff_len > FCS_L) ? eff_len - FCS_L : '0;
                end
            end else if (bit_v && state_q != HUNT) begin
                if (state_q == FLAG) begin
                    state_d = DATA;
                    vf_d    = 1'b1;
                    crc_d   = '1;
                end
                byte_v    = {bit_out, asm_q[7:1]};
                asm_d     = byte_v;
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    crc_d  = crc_byte(crc_q, byte_v);
                    hold_d = {byte_v, hold_q[FCS_WIDTH-1:8]};
                    if (byte_cnt_q != CNT_SAT) byte_cnt_d = byte_cnt_q + 1'b1;
                    // Oldest held byte is payload once FCS_BYTES newer ones exist
                    if (byte_cnt_q >= FCS_L && byte_cnt_q < MAX_L) begin
                        data_d = hold_q[7:0];
                        dv_d   = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state_q    <= HUNT;
            ones_q     <= '0;
            dl_q       <= '0;
            dl_cnt_q   <= '0;
            asm_q      <= '0;
            bit_cnt_q  <= '0;
            hold_q     <= '0;
            crc_q      <= '0;
            byte_cnt_q <= '0;
            data_q     <= '0;
            dv_q       <= 1'b0;
            flag_q     <= 1'b0;
            abort_q    <= 1'b0;
            vf_q       <= 1'b0;
            eof_q      <= 1'b0;
            err_q      <= 1'b0;
            len_q      <= '0;
        end else begin
            state_q    <= state_d;
            ones_q     <= ones_d;
            dl_q       <= dl_d;
            dl_cnt_q   <= dl_cnt_d;
            asm_q      <= asm_d;
            bit_cnt_q  <= bit_cnt_d;
            hold_q     <= hold_d;
            crc_q      <= crc_d;
            byte_cnt_q <= byte_cnt_d;
            data_q     <= data_d;
            dv_q       <= dv_d;
            flag_q     <= flag_d;
            abort_q    <= abort_d;
            vf_q       <= vf_d;
            eof_q      <= eof_d;
            err_q      <= err_d;
            len_q      <= len_d;
        end
    end

    assign bus.DataOut        = data_q;
    assign bus.Rx_DataValid   = dv_q;
    assign bus.Rx_FlagDetect  = flag_q;
    assign bus.Rx_AbortDetect = abort_q;
    assign bus.Rx_ValidFrame  = vf_q;
    assign bus.Rx_EoF         = eof_q;
    assign bus.Rx_FrameError  = err_q;
    assign bus.Rx_FrameLen    = len_q;

`ifdef HDLC_RX_IDLE_DETECT_EN
    logic idle_q, idle_d;

    always_comb begin
        idle_d = idle_q;
        if (bus.RxEN) begin
            if (!bus.Rx)              idle_d = 1'b0;
            else if (ones_d == 4'hF)  idle_d = 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst) idle_q <= 1'b0;
        else      idle_q <= idle_d;
    end

    assign bus.Rx_Idle = idle_q;
`endif
endmodule

// File: tb/tb_hdlc_rx_deframer.sv
// Directed bench for hdlc_rx_deframer: three instances cover CRC-16,
// CRC-32 and a short maximum frame length.
module tb_hdlc_rx_deframer;
    typedef logic [7:0] bq_t [$];

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rx  = 1'b1;
    logic en  = 1'b0;
    int   sel = 0;
    int   tx_ones = 0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    hdlc_rx_deframer_if #(.LEN_W(8)) if16 ();
    hdlc_rx_deframer_if #(.LEN_W(8)) if32 ();
    hdlc_rx_deframer_if #(.LEN_W(8)) ifmx ();

    assign if16.Rx   = rx;
    assign if32.Rx   = rx;
    assign ifmx.Rx   = rx;
    assign if16.RxEN = en && (sel == 0);
    assign if32.RxEN = en && (sel == 1);
    assign ifmx.RxEN = en && (sel == 2);

    hdlc_rx_deframer #(.FCS_WIDTH(16)) u16 (
        .Clk(clk), .Rst(rst), .bus(if16.slave));
    hdlc_rx_deframer #(.FCS_WIDTH(32)) u32 (
        .Clk(clk), .Rst(rst), .bus(if32.slave));
    hdlc_rx_deframer #(.FCS_WIDTH(16), .MAX_FRAME_BYTES(6)) umx (
        .Clk(clk), .Rst(rst), .bus(ifmx.slave));

    logic [7:0] m_data;
    logic       m_dv, m_flag, m_abort, m_vf, m_eof, m_err;
    logic [7:0] m_len;

    assign m_data  = (sel == 0) ? if16.DataOut :
                     (sel == 1) ? if32.DataOut : ifmx.DataOut;
    assign m_dv    = (sel == 0) ? if16.Rx_DataValid :
                     (sel == 1) ? if32.Rx_DataValid : ifmx.Rx_DataValid;
    assign m_flag  = (sel == 0) ? if16.Rx_FlagDetect :
                     (sel == 1) ? if32.Rx_FlagDetect : ifmx.Rx_FlagDetect;
    assign m_abort = (sel == 0) ? if16.Rx_AbortDetect :
                     (sel == 1) ? if32.Rx_AbortDetect : ifmx.Rx_AbortDetect;
    assign m_vf    = (sel == 0) ? if16.Rx_ValidFrame :
                     (sel == 1) ? if32.Rx_ValidFrame : ifmx.Rx_ValidFrame;
    assign m_eof   = (sel == 0) ? if16.Rx_EoF :
                     (sel == 1) ? if32.Rx_EoF : ifmx.Rx_EoF;
    assign m_err   = (sel == 0) ? if16.Rx_FrameError :
                     (sel == 1) ? if32.Rx_FrameError : ifmx.Rx_FrameError;
    assign m_len   = (sel == 0) ? if16.Rx_FrameLen :
                     (sel == 1) ? if32.Rx_FrameLen : ifmx.Rx_FrameLen;

    bq_t        got;
    int         n_flag = 0, n_abort = 0, n_eof = 0, n_rise = 0, n_fall = 0;
    logic       last_err = 1'b0;
    logic [7:0] last_len = '0;
    logic       vf_prev = 1'b0;

    always @(negedge clk) begin
        if (m_dv) got.push_back(m_data);
        if (m_flag) n_flag++;
        if (m_abort) n_abort++;
        if (m_eof) begin
            n_eof++;
            last_err = m_err;
            last_len = m_len;
        end
        if (!vf_prev && m_vf) n_rise++;
        if (vf_prev && !m_vf) n_fall++;
        vf_prev = m_vf;
    end

    function automatic logic [31:0] tb_fcs(input bq_t pl, input int w);
        logic [31:0] c, poly;
        logic        fb;
        poly = (w == 32) ? 32'hEDB88320 : 32'h00008408;
        c    = (w == 32) ? 32'hFFFFFFFF : 32'h0000FFFF;
        foreach (pl[i]) begin
            for (int k = 0; k < 8; k++) begin
                fb = c[0] ^ pl[i][k];
                c  = c >> 1;
                if (fb) c = c ^ poly;
            end
        end
        c = ~c;
        if (w == 16) c[31:16] = '0;
        return c;
    endfunction

    task automatic send_bit(input logic b);
        @(negedge clk);
        rx = b;
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
    endtask

    task automatic send_flag();
        send_bit(1'b0);
        repeat (6) send_bit(1'b1);
        send_bit(1'b0);
        tx_ones = 0;
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int k = 0; k < 8; k++) begin
            send_bit(v[k]);
            if (v[k]) tx_ones++;
            else tx_ones = 0;
            if (tx_ones == 5) begin
                send_bit(1'b0);
                tx_ones = 0;
            end
        end
    endtask

    task automatic send_body(input bq_t pl, input int w, input int flip);
        logic [31:0] fcs;
        fcs = tb_fcs(pl, w);
        if (flip >= 0) fcs[flip] = ~fcs[flip];
        foreach (pl[i]) send_byte(pl[i]);
        for (int i = 0; i < w / 8; i++) send_byte(fcs[8*i +: 8]);
    endtask

    task automatic send_frame(input bq_t pl, input int w, input int flip);
        send_flag();
        send_body(pl, w, flip);
        send_flag();
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ((|{if16.DataOut, if16.Rx_DataValid, if16.Rx_FlagDetect,
               if16.Rx_AbortDetect, if16.Rx_ValidFrame, if16.Rx_EoF,
               if16.Rx_FrameError, if16.Rx_FrameLen}) !== 1'b0) begin
            failures++;
            $display("FAIL reset16 outputs nonzero len=%0h data=%0h",
                     if16.Rx_FrameLen, if16.DataOut);
        end
        checks++;
        if ((|{if32.DataOut, if32.Rx_DataValid, if32.Rx_FlagDetect,
               if32.Rx_AbortDetect, if32.Rx_ValidFrame, if32.Rx_EoF,
               if32.Rx_FrameError, if32.Rx_FrameLen,
               ifmx.DataOut, ifmx.Rx_ValidFrame, ifmx.Rx_EoF}) !== 1'b0) begin
            failures++;
            $display("FAIL reset32_mx outputs nonzero got=1 exp=0");
        end
    endtask

    task automatic test_good16();
        bq_t pl;
        int  b0, f0, e0, r0;
        pl = '{8'h01, 8'h02, 8'h03};
        sel = 0;
        b0 = got.size(); f0 = n_flag; e0 = n_eof; r0 = n_rise;
        send_frame(pl, 16, -1);
        checks++;
        if (got.size() - b0 !== 3) begin
            failures++;
            $display("FAIL good16_count got=%0d exp=3", got.size() - b0);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (b0 + i >= got.size() || got[b0+i] !== pl[i]) begin
                failures++;
                $display("FAIL good16_byte%0d got=%0h exp=%0h",
                         i, got[b0+i], pl[i]);
            end
        end
        checks++;
        if (n_eof - e0 !== 1 || last_err !== 1'b0 || last_len !== 8'd3) begin
            failures++;
            $display("FAIL good16_eof got=%0d/%0b/%0d exp=1/0/3",
                     n_eof - e0, last_err, last_len);
        end
        checks++;
        if (n_flag - f0 !== 2 || n_rise - r0 !== 1) begin
            failures++;
            $display("FAIL good16_flags got=%0d/%0d exp=2/1",
                     n_flag - f0, n_rise - r0);
        end
    endtask

    task automatic test_stuffing();
        bq_t pl;
        int  b0, f0, a0, e0;
        pl = '{8'h1F, 8'hFF, 8'hFF};
        sel = 0;
        b0 = got.size(); f0 = n_flag; a0 = n_abort; e0 = n_eof;
        send_frame(pl, 16, -1);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (b0 + i >= got.size() || got[b0+i] !== pl[i]) begin
                failures++;
                $display("FAIL stuff_byte%0d got=%0h exp=%0h",
                         i, got[b0+i], pl[i]);
            end
        end
        checks++;
        if (n_flag - f0 !== 2 || n_abort - a0 !== 0) begin
            failures++;
            $display("FAIL stuff_spurious flags/aborts got=%0d/%0d exp=2/0",
                     n_flag - f0, n_abort - a0);
        end
        checks++;
        if (n_eof - e0 !== 1 || last_err !== 1'b0 || last_len !== 8'd3) begin
            failures++;
            $display("FAIL stuff_eof got=%0d/%0b/%0d exp=1/0/3",
                     n_eof - e0, last_err, last_len);
        end
    endtask

    task automatic test_runt_min();
        bq_t pl;
        sel = 0;
        pl = '{8'h11};
        send_frame(pl, 16, -1);
        checks++;
        if (last_err !== 1'b1 || last_len !== 8'd1) begin
            failures++;
            $display("FAIL runt got=%0b/%0d exp=1/1", last_err, last_len);
        end
        pl = '{8'h22, 8'h33};
        send_frame(pl, 16, -1);
        checks++;
        if (last_err !== 1'b0 || last_len !== 8'd2) begin
            failures++;
            $display("FAIL min_ok got=%0b/%0d exp=0/2", last_err, last_len);
        end
    endtask

    task automatic test_abort();
        bq_t pl;
        int  a0, e0, fl0, b0;
        sel = 0;
        a0 = n_abort; e0 = n_eof; fl0 = n_fall;
        send_flag();
        send_byte(8'hA5);
        send_byte(8'h3C);
        checks++;
        if (m_vf !== 1'b1) begin
            failures++;
            $display("FAIL abort_vf_before got=%0b exp=1", m_vf);
        end
        repeat (7) send_bit(1'b1);
        repeat (2) @(negedge clk);
        checks++;
        if (n_abort - a0 !== 1 || n_eof - e0 !== 0 || n_fall - fl0 !== 1) begin
            failures++;
            $display("FAIL abort got abort/eof/fall=%0d/%0d/%0d exp=1/0/1",
                     n_abort - a0, n_eof - e0, n_fall - fl0);
        end
        pl = '{8'h01, 8'h02, 8'h03};
        b0 = got.size(); e0 = n_eof;
        send_frame(pl, 16, -1);
        checks++;
        if (got.size() - b0 !== 3 || n_eof - e0 !== 1 || last_err !== 1'b0) begin
            failures++;
            $display("FAIL abort_recover got=%0d/%0d/%0b exp=3/1/0",
                     got.size() - b0, n_eof - e0, last_err);
        end
    endtask

    task automatic test_nonoctet_flags();
        bq_t pl;
        int  f0, e0;
        sel = 0;
        pl = '{8'h5A, 8'h6B, 8'h7C};
        e0 = n_eof;
        send_flag();
        send_body(pl, 16, -1);
        repeat (5) send_bit(1'b0);
        send_flag();
        repeat (3) @(negedge clk);
        checks++;
        if (n_eof - e0 !== 1 || last_err !== 1'b1) begin
            failures++;
            $display("FAIL nonoctet got=%0d/%0b exp=1/1", n_eof - e0, last_err);
        end
        f0 = n_flag; e0 = n_eof;
        repeat (3) send_flag();
        repeat (3) @(negedge clk);
        checks++;
        if (n_flag - f0 !== 3 || n_eof - e0 !== 0) begin
            failures++;
            $display("FAIL three_flags got=%0d/%0d exp=3/0",
                     n_flag - f0, n_eof - e0);
        end
    endtask

    task automatic test_fcs32();
        bq_t pl;
        int  b0;
        sel = 1;
        pl = '{8'hA1, 8'hB2, 8'hC3};
        send_frame(pl, 32, -1);
        checks++;
        if (last_err !== 1'b0 || last_len !== 8'd3) begin
            failures++;
            $display("FAIL fcs32_good got=%0b/%0d exp=0/3", last_err, last_len);
        end
        pl = '{8'h01, 8'h02, 8'h03, 8'h04};
        b0 = got.size();
        send_frame(pl, 32, 5);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (b0 + i >= got.size() || got[b0+i] !== pl[i]) begin
                failures++;
                $display("FAIL fcs32_byte%0d got=%0h exp=%0h",
                         i, got[b0+i], pl[i]);
            end
        end
        checks++;
        if (last_err !== 1'b1 || last_len !== 8'd4) begin
            failures++;
            $display("FAIL fcs32_bad got=%0b/%0d exp=1/4", last_err, last_len);
        end
    endtask

    task automatic test_max_len();
        bq_t pl;
        int  b0;
        sel = 2;
        send_flag();
        pl = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
        b0 = got.size();
        send_frame(pl, 16, -1);
        checks++;
        if (got.size() - b0 !== 4) begin
            failures++;
            $display("FAIL max_count got=%0d exp=4", got.size() - b0);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (b0 + i >= got.size() || got[b0+i] !== pl[i]) begin
                failures++;
                $display("FAIL max_byte%0d got=%0h exp=%0h",
                         i, got[b0+i], pl[i]);
            end
        end
        checks++;
        if (last_err !== 1'b1 || last_len !== 8'd4) begin
            failures++;
            $display("FAIL max_eof got=%0b/%0d exp=1/4", last_err, last_len);
        end
    endtask

    task automatic test_reset_midframe();
        bq_t pl;
        int  e0;
        sel = 0;
        send_flag();
        send_byte(8'h55);
        send_byte(8'hAA);
        send_byte(8'h0F);
        e0 = n_eof;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (if16.Rx_ValidFrame !== 1'b0 || n_eof - e0 !== 0) begin
            failures++;
            $display("FAIL rst_mid got vf/eof=%0b/%0d exp=0/0",
                     if16.Rx_ValidFrame, n_eof - e0);
        end
        pl = '{8'hC0, 8'hFF, 8'hEE};
        send_frame(pl, 16, -1);
        checks++;
        if (n_eof - e0 !== 1 || last_err !== 1'b0 || last_len !== 8'd3) begin
            failures++;
            $display("FAIL rst_recover got=%0d/%0b/%0d exp=1/0/3",
                     n_eof - e0, last_err, last_len);
        end
    endtask

`ifdef HDLC_RX_IDLE_DETECT_EN
    task automatic test_idle();
        int a0;
        sel = 0;
        a0 = n_abort;
        repeat (14) send_bit(1'b1);
        checks++;
        if (if16.Rx_Idle !== 1'b0) begin
            failures++;
            $display("FAIL idle_early got=%0b exp=0", if16.Rx_Idle);
        end
        send_bit(1'b1);
        checks++;
        if (if16.Rx_Idle !== 1'b1 || n_abort - a0 !== 1) begin
            failures++;
            $display("FAIL idle_set got=%0b/%0d exp=1/1",
                     if16.Rx_Idle, n_abort - a0);
        end
        send_bit(1'b0);
        checks++;
        if (if16.Rx_Idle !== 1'b0) begin
            failures++;
            $display("FAIL idle_clear got=%0b exp=0", if16.Rx_Idle);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_good16();
        test_stuffing();
        test_runt_min();
        test_abort();
        test_nonoctet_flags();
        test_fcs32();
        test_max_len();
        test_reset_midframe();
`ifdef HDLC_RX_IDLE_DETECT_EN
        test_idle();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
